// File: rtl/key_arb_pkg.sv
// -----------------------------------------------------------------------------
// key_arb_pkg
//   Shared types and constants for the key request arbiter.
//   - key_arb_state_e : arbiter FSM states
//   - KEY_W_DEF       : default key width (matches the responder counter)
//   - STAT_W          : width of the optional statistics counters
// -----------------------------------------------------------------------------
package key_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } key_arb_state_e;

    localparam int KEY_W_DEF = 4;
    localparam int STAT_W    = 16;

endpackage

// File: rtl/key_req_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the first requesting client at or
//   after i_ptr, wrapping around N.
// Ports
//   i_req     in  N          request vector
//   i_ptr     in  $clog2(N)  highest-priority index for this pick
//   o_gnt     out N          one-hot grant (all zero when nothing requests)
//   o_gnt_idx out $clog2(N)  binary index of the granted client
//   o_any     out 1          at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    always_comb begin
        int w_idx;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int off = 0; off < N; off++) begin
            w_idx = (int'(i_ptr) + off) % N;
            if (!o_any && i_req[IW'(w_idx)]) begin
                o_any              = 1'b1;
                o_gnt[IW'(w_idx)]  = 1'b1;
                o_gnt_idx          = IW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/key_req_arb.sv
// -----------------------------------------------------------------------------
// key_req_arb
//   Shares one key-match responder among NUM_REQ clients. One transaction is in
//   flight at a time; the granted client's key is held on the responder until
//   it acks or TIMEOUT cycles pass, then a one-cycle done/timeout pulse is sent
//   back to that client. o_rsp_req/o_rsp_key are registered, so the responder's
//   combinational ack never loops back into the request.
//   Optional build macro KEY_ARB_STATS_EN adds saturating hit/timeout counters.
// Ports
//   clk            in   1                clock
//   rst            in   1                synchronous active-high reset
//   i_cli_req      in   NUM_REQ          level request per client
//   i_cli_key      in   NUM_REQ x KEY_W  key per client
//   o_cli_done     out  NUM_REQ          1-cycle pulse: key matched
//   o_cli_timeout  out  NUM_REQ          1-cycle pulse: no match in time
//   o_rsp_req      out  1                request to responder
//   o_rsp_key      out  KEY_W            key to responder
//   i_rsp_ack      in   1                responder match
//   o_stat_hits    out  STAT_W           (KEY_ARB_STATS_EN) done pulse count
//   o_stat_tmo     out  STAT_W           (KEY_ARB_STATS_EN) timeout pulse count
// -----------------------------------------------------------------------------
module key_req_arb
    import key_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              i_cli_req,
    input  logic [NUM_REQ-1:0][KEY_W-1:0]   i_cli_key,
    output logic [NUM_REQ-1:0]              o_cli_done,
    output logic [NUM_REQ-1:0]              o_cli_timeout,
    output logic                            o_rsp_req,
    output logic [KEY_W-1:0]                o_rsp_key,
    input  logic                            i_rsp_ack
`ifdef KEY_ARB_STATS_EN
   ,output logic [STAT_W-1:0]               o_stat_hits,
    output logic [STAT_W-1:0]               o_stat_tmo
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    key_arb_state_e       r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_grant, w_grant_nxt;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]     r_wait_cnt, w_wait_cnt_nxt;
    logic                 r_rsp_req, w_rsp_req_nxt;
    logic [KEY_W-1:0]     r_rsp_key, w_rsp_key_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic [NUM_REQ-1:0]   r_tmo, w_tmo_nxt;
    logic                 w_hit, w_miss;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [PTR_W-1:0]     w_arb_idx;
    logic                 w_arb_any;
    logic [KEY_W-1:0]     w_key_sel;
    logic                 w_ack;
    logic                 w_last;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req     (i_cli_req),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx),
        .o_any     (w_arb_any)
    );

    // One-hot AND-OR mux of the winning client's key.
    always_comb begin
        w_key_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_key_sel = w_key_sel | ({KEY_W{w_arb_gnt[i]}} & i_cli_key[i]);
        end
    end

    // Ack only counts while a request is actually on the responder.
    assign w_ack  = r_rsp_req && i_rsp_ack;
    assign w_last = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_any)       w_state_nxt = ISSUE;
            ISSUE:   if (w_ack || w_last) w_state_nxt = RESP;
            RESP:                         w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values. Ack is tested before the limit so a
    // match on the final wait cycle still reports done.
    always_comb begin
        w_rsp_req_nxt  = r_rsp_req;
        w_rsp_key_nxt  = r_rsp_key;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_wait_cnt_nxt = r_wait_cnt;
        w_done_nxt     = '0;
        w_tmo_nxt      = '0;
        w_hit          = 1'b0;
        w_miss         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_rsp_req_nxt  = 1'b1;
                    w_rsp_key_nxt  = w_key_sel;
                    w_grant_nxt    = w_arb_idx;
                    w_wait_cnt_nxt = '0;
                end
            end
            ISSUE: begin
                if (w_ack) begin
                    w_rsp_req_nxt       = 1'b0;
                    w_done_nxt[r_grant] = 1'b1;
                    w_hit               = 1'b1;
                end else if (w_last) begin
                    w_rsp_req_nxt       = 1'b0;
                    w_tmo_nxt[r_grant]  = 1'b1;
                    w_miss              = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            RESP: begin
                w_rr_ptr_nxt = (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_req  <= 1'b0;
            r_rsp_key  <= '0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
            r_done     <= '0;
            r_tmo      <= '0;
        end else begin
            r_rsp_req  <= w_rsp_req_nxt;
            r_rsp_key  <= w_rsp_key_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_done     <= w_done_nxt;
            r_tmo      <= w_tmo_nxt;
        end
    end

    assign o_rsp_req     = r_rsp_req;
    assign o_rsp_key     = r_rsp_key;
    assign o_cli_done    = r_done;
    assign o_cli_timeout = r_tmo;

`ifdef KEY_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_hits;
    logic [STAT_W-1:0] r_stat_tmo;

    // Counters saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits <= '0;
            r_stat_tmo  <= '0;
        end else begin
            if (w_hit  && (r_stat_hits != '1)) r_stat_hits <= r_stat_hits + 1'b1;
            if (w_miss && (r_stat_tmo  != '1)) r_stat_tmo  <= r_stat_tmo + 1'b1;
        end
    end

    assign o_stat_hits = r_stat_hits;
    assign o_stat_tmo  = r_stat_tmo;
`endif

endmodule

// File: tb/tb_key_req_arb.sv
// -----------------------------------------------------------------------------
// tb_key_req_arb
//   Directed bench for key_req_arb. Two instances: u_dut (TIMEOUT=16) and
//   u_t4 (TIMEOUT=4), each with its own responder model: a 4-bit down-counter
//   starting at 4'hF after reset, ack = req && key == counter.
// -----------------------------------------------------------------------------
module tb_key_req_arb;
    import key_arb_pkg::*;

    localparam int N  = 4;
    localparam int KW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]          cli_req, cli_req_t4;
    logic [N-1:0][KW-1:0]  cli_key, cli_key_t4;
    logic [N-1:0]          done, tmo, done_t4, tmo_t4;
    logic                  rsp_req, rsp_req_t4;
    logic [KW-1:0]         rsp_key, rsp_key_t4;
    logic                  rsp_ack, rsp_ack_t4;
    logic [KW-1:0]         cnt, cnt_t4;
`ifdef KEY_ARB_STATS_EN
    logic [STAT_W-1:0]     hits, tmos, hits_t4, tmos_t4;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    key_req_arb #(.NUM_REQ(N), .KEY_W(KW), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst),
        .i_cli_req(cli_req), .i_cli_key(cli_key),
        .o_cli_done(done), .o_cli_timeout(tmo),
        .o_rsp_req(rsp_req), .o_rsp_key(rsp_key), .i_rsp_ack(rsp_ack)
`ifdef KEY_ARB_STATS_EN
       ,.o_stat_hits(hits), .o_stat_tmo(tmos)
`endif
    );

    key_req_arb #(.NUM_REQ(N), .KEY_W(KW), .TIMEOUT(4)) u_t4 (
        .clk(clk), .rst(rst),
        .i_cli_req(cli_req_t4), .i_cli_key(cli_key_t4),
        .o_cli_done(done_t4), .o_cli_timeout(tmo_t4),
        .o_rsp_req(rsp_req_t4), .o_rsp_key(rsp_key_t4), .i_rsp_ack(rsp_ack_t4)
`ifdef KEY_ARB_STATS_EN
       ,.o_stat_hits(hits_t4), .o_stat_tmo(tmos_t4)
`endif
    );

    // Responder models.
    always @(posedge clk) begin
        if (rst) begin
            cnt    <= 4'hF;
            cnt_t4 <= 4'hF;
        end else begin
            cnt    <= cnt - 4'd1;
            cnt_t4 <= cnt_t4 - 4'd1;
        end
    end
    assign rsp_ack    = rsp_req    && (rsp_key    == cnt);
    assign rsp_ack_t4 = rsp_req_t4 && (rsp_key_t4 == cnt_t4);

    // Always-on protocol properties.
    assert property (@(posedge clk) disable iff (rst)
        (rsp_req && $past(rsp_req)) |-> (rsp_key == $past(rsp_key)))
        else begin $display("FAIL key_stable: rsp_key=%h prev=%h", rsp_key, $past(rsp_key)); n_mis++; end
    assert property (@(posedge clk) $onehot0(done | tmo))
        else begin $display("FAIL one_pulse: done=%b tmo=%b", done, tmo); n_mis++; end
    assert property (@(posedge clk) $onehot0(done_t4 | tmo_t4))
        else begin $display("FAIL one_pulse_t4: done=%b tmo=%b", done_t4, tmo_t4); n_mis++; end
    assert property (@(posedge clk) disable iff (rst) $past(rsp_req && rsp_ack) |-> !rsp_req)
        else begin $display("FAIL req_after_ack1: rsp_req=1 want 0"); n_mis++; end
    assert property (@(posedge clk) disable iff (rst) $past(rsp_req && rsp_ack, 2) |-> !rsp_req)
        else begin $display("FAIL req_after_ack2: rsp_req=1 want 0"); n_mis++; end

    task automatic do_reset();
        rst        = 1'b1;
        cli_req    = '0;
        cli_req_t4 = '0;
        cli_key    = '0;
        cli_key_t4 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait for the next result pulse. Called at a negedge; returns the
    // pulse vectors, the number of cycles waited and whether the responder
    // model was acking on the cycle before the pulse.
    task automatic wait_result(input bit sel, input int budget,
                               output logic [N-1:0] d, output logic [N-1:0] t,
                               output int n, output bit ok, output bit ack_seen);
        logic          p_req;
        logic [KW-1:0] p_key, p_cnt;
        ok = 1'b0; ack_seen = 1'b0; n = 0; d = '0; t = '0;
        p_req = sel ? rsp_req_t4 : rsp_req;
        p_key = sel ? rsp_key_t4 : rsp_key;
        p_cnt = sel ? cnt_t4     : cnt;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            d = sel ? done_t4 : done;
            t = sel ? tmo_t4  : tmo;
            if ((d | t) != '0) begin
                ok       = 1'b1;
                n        = i;
                ack_seen = p_req && (p_key == p_cnt);
                break;
            end
            p_req = sel ? rsp_req_t4 : rsp_req;
            p_key = sel ? rsp_key_t4 : rsp_key;
            p_cnt = sel ? cnt_t4     : cnt;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rsp_req !== 1'b0) begin $display("FAIL reset_rsp_req: got %b want 0", rsp_req); n_mis++; end
        n_cmp++; if (rsp_key !== 4'h0) begin $display("FAIL reset_rsp_key: got %h want 0", rsp_key); n_mis++; end
        n_cmp++; if (done !== 4'b0000) begin $display("FAIL reset_done: got %b want 0000", done); n_mis++; end
        n_cmp++; if (tmo !== 4'b0000) begin $display("FAIL reset_tmo: got %b want 0000", tmo); n_mis++; end
        n_cmp++; if (u_dut.r_rr_ptr !== 2'd0) begin $display("FAIL reset_rr_ptr: got %0d want 0", u_dut.r_rr_ptr); n_mis++; end
        n_cmp++; if (u_dut.r_state !== IDLE) begin $display("FAIL reset_state: got %0d want IDLE", u_dut.r_state); n_mis++; end
    endtask

    task automatic test_single();
        logic [N-1:0] d, t; int n; bit ok, ack_seen;
        do_reset();
        cli_key[0] = 4'hA;
        cli_req    = 4'b0001;
        @(negedge clk);
        n_cmp++; if (rsp_req !== 1'b1) begin $display("FAIL single_latency: rsp_req=%b want 1", rsp_req); n_mis++; end
        n_cmp++; if (rsp_key !== 4'hA) begin $display("FAIL single_key: rsp_key=%h want a", rsp_key); n_mis++; end
        // Key change and request drop after grant must not disturb the transaction.
        cli_key[0] = 4'h3;
        cli_req    = 4'b0000;
        wait_result(1'b0, 20, d, t, n, ok, ack_seen);
        n_cmp++; if (!ok) begin $display("FAIL single_no_pulse: none within 20 cycles"); n_mis++; end
        n_cmp++; if (d !== 4'b0001 || t !== 4'b0000) begin $display("FAIL single_pulse: done=%b tmo=%b want 0001/0000", d, t); n_mis++; end
        n_cmp++; if (n > 16) begin $display("FAIL single_delay: %0d cycles want <=16", n); n_mis++; end
        n_cmp++; if (!ack_seen) begin $display("FAIL single_match: done without model counter == a"); n_mis++; end
        @(negedge clk);
        n_cmp++; if (done !== 4'b0000) begin $display("FAIL single_once: done=%b want 0000", done); n_mis++; end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] d, t; int n; bit ok, ack_seen;
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_vec;
        do_reset();
        cli_key = {4'hF, 4'hB, 4'h7, 4'h3};
        cli_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_vec = '0;
            exp_vec[exp_idx[k]] = 1'b1;
            wait_result(1'b0, 40, d, t, n, ok, ack_seen);
            n_cmp++; if (!ok) begin $display("FAIL rr_no_pulse[%0d]: none within 40 cycles", k); n_mis++; end
            n_cmp++; if (d !== exp_vec || t !== 4'b0000) begin $display("FAIL rr_order[%0d]: done=%b tmo=%b want %b/0000", k, d, t, exp_vec); n_mis++; end
            n_cmp++; if (!ack_seen) begin $display("FAIL rr_match[%0d]: done without matching key", k); n_mis++; end
            n_cmp++; if (rsp_req !== 1'b0) begin $display("FAIL rr_gap[%0d]: rsp_req=%b want 0", k, rsp_req); n_mis++; end
        end
        cli_req = 4'b0000;
    endtask

    task automatic test_timeout();
        logic [N-1:0] d, t; int n; bit ok, ack_seen;
        do_reset();
        // Key equal to the counter value at grant: not seen again for 16 cycles.
        cli_key_t4[0] = cnt_t4;
        cli_req_t4    = 4'b0001;
        @(negedge clk);
        n_cmp++; if (rsp_req_t4 !== 1'b1) begin $display("FAIL tmo_latency: rsp_req=%b want 1", rsp_req_t4); n_mis++; end
        cli_req_t4 = 4'b0000;
        wait_result(1'b1, 10, d, t, n, ok, ack_seen);
        n_cmp++; if (!ok) begin $display("FAIL tmo_no_pulse: none within 10 cycles"); n_mis++; end
        n_cmp++; if (t !== 4'b0001 || d !== 4'b0000) begin $display("FAIL tmo_pulse: done=%b tmo=%b want 0000/0001", d, t); n_mis++; end
        n_cmp++; if (n != 4) begin $display("FAIL tmo_delay: %0d cycles want 4", n); n_mis++; end
    endtask

    task automatic test_ack_at_limit();
        logic [N-1:0] d, t; int n; bit ok, ack_seen;
        do_reset();
        // Counter reaches this key on the fourth ISSUE cycle (wait_cnt == 3).
        cli_key_t4[3] = cnt_t4 - 4'd4;
        cli_req_t4    = 4'b1000;
        @(negedge clk);
        n_cmp++; if (rsp_req_t4 !== 1'b1 || rsp_key_t4 !== cli_key_t4[3]) begin
            $display("FAIL limit_issue: rsp_req=%b key=%h want 1/%h", rsp_req_t4, rsp_key_t4, cli_key_t4[3]); n_mis++; end
        cli_req_t4 = 4'b0000;
        wait_result(1'b1, 10, d, t, n, ok, ack_seen);
        n_cmp++; if (!ok) begin $display("FAIL limit_no_pulse: none within 10 cycles"); n_mis++; end
        n_cmp++; if (d !== 4'b1000 || t !== 4'b0000) begin $display("FAIL limit_pulse: done=%b tmo=%b want 1000/0000", d, t); n_mis++; end
        n_cmp++; if (n != 4) begin $display("FAIL limit_delay: %0d cycles want 4", n); n_mis++; end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] d, t; int n; bit ok, ack_seen;
        do_reset();
        cli_key[0] = 4'h2;
        cli_req    = 4'b0001;
        @(negedge clk);
        cli_req = 4'b0000;
        wait_result(1'b0, 20, d, t, n, ok, ack_seen);
        n_cmp++; if (!ok || d !== 4'b0001) begin $display("FAIL mid_pre_done: ok=%b done=%b want 1/0001", ok, d); n_mis++; end
        @(negedge clk);
        n_cmp++; if (u_dut.r_rr_ptr !== 2'd1) begin $display("FAIL mid_ptr_adv: rr_ptr=%0d want 1", u_dut.r_rr_ptr); n_mis++; end
        cli_key[1] = cnt;
        cli_req    = 4'b0010;
        @(negedge clk);
        n_cmp++; if (rsp_req !== 1'b1) begin $display("FAIL mid_issue: rsp_req=%b want 1", rsp_req); n_mis++; end
        cli_req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_req !== 1'b0) begin $display("FAIL mid_rsp_req: got %b want 0", rsp_req); n_mis++; end
        n_cmp++; if (u_dut.r_rr_ptr !== 2'd0) begin $display("FAIL mid_rr_ptr: got %0d want 0", u_dut.r_rr_ptr); n_mis++; end
        n_cmp++; if ((done | tmo) !== 4'b0000) begin $display("FAIL mid_pulse: done=%b tmo=%b want 0", done, tmo); n_mis++; end
        n_cmp++; if (u_dut.r_state !== IDLE) begin $display("FAIL mid_state: got %0d want IDLE", u_dut.r_state); n_mis++; end
        rst        = 1'b0;
        cli_key[1] = 4'h5;
        cli_key[2] = 4'h9;
        cli_req    = 4'b0110;
        @(negedge clk);
        n_cmp++; if (rsp_req !== 1'b1 || rsp_key !== 4'h5) begin
            $display("FAIL mid_regrant: rsp_req=%b key=%h want 1/5", rsp_req, rsp_key); n_mis++; end
        cli_req = 4'b0000;
        wait_result(1'b0, 20, d, t, n, ok, ack_seen);
        n_cmp++; if (!ok || d !== 4'b0010 || t !== 4'b0000) begin
            $display("FAIL mid_regrant_done: ok=%b done=%b tmo=%b want 1/0010/0000", ok, d, t); n_mis++; end
    endtask

`ifdef KEY_ARB_STATS_EN
    task automatic t4_txn(input bit hit);
        logic [N-1:0] d, t; int n; bit ok, ack_seen;
        cli_key_t4[0] = hit ? (cnt_t4 - 4'd1) : cnt_t4;
        cli_req_t4    = 4'b0001;
        @(negedge clk);
        cli_req_t4 = 4'b0000;
        wait_result(1'b1, 10, d, t, n, ok, ack_seen);
        n_cmp++; if (!ok || d !== (hit ? 4'b0001 : 4'b0000) || t !== (hit ? 4'b0000 : 4'b0001)) begin
            $display("FAIL stats_txn: ok=%b done=%b tmo=%b hit=%b", ok, d, t, hit); n_mis++; end
        @(negedge clk);
    endtask

    task automatic test_stats();
        do_reset();
        n_cmp++; if (hits_t4 !== 16'd0 || tmos_t4 !== 16'd0) begin $display("FAIL stats_reset: hits=%0d tmo=%0d want 0/0", hits_t4, tmos_t4); n_mis++; end
        t4_txn(1'b1); t4_txn(1'b0); t4_txn(1'b1); t4_txn(1'b0); t4_txn(1'b1);
        n_cmp++; if (hits_t4 !== 16'd3) begin $display("FAIL stats_hits: got %0d want 3", hits_t4); n_mis++; end
        n_cmp++; if (tmos_t4 !== 16'd2) begin $display("FAIL stats_tmo: got %0d want 2", tmos_t4); n_mis++; end
        force u_t4.r_stat_hits = 16'hFFFF;
        @(negedge clk);
        release u_t4.r_stat_hits;
        t4_txn(1'b1);
        n_cmp++; if (hits_t4 !== 16'hFFFF) begin $display("FAIL stats_sat: got %h want ffff", hits_t4); n_mis++; end
        n_cmp++; if (tmos_t4 !== 16'd2) begin $display("FAIL stats_tmo_hold: got %0d want 2", tmos_t4); n_mis++; end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
`ifdef KEY_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
